// File: rtl/coef_pkg.sv
// coef_pkg: shared constants and FSM state encoding for the coefficient bank.
// Provides default word width (from the fixed-point header width), node and slot counts.
package coef_pkg;

   // Width of one fixed-point coefficient word.
   localparam int FX_W   = 16;
   localparam int N_DEF  = FX_W;
   localparam int ND_DEF = 4;
   localparam int NC_DEF = 4;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      READY,
      DRAIN
   } state_t;

endpackage

// File: rtl/coef_node.sv
// coef_node: one node's NC-word coefficient store with saturating write counter.
// Ports: clk, rst (async active-low), we, clr, din -> words, loaded, fill.
module coef_node
   import coef_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int NC = NC_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we,
   input  logic            clr,
   input  logic [N-1:0]    din,
   output logic [NC*N-1:0] words,
   output logic            loaded,
   output logic            fill
);

   localparam int CW = $clog2(NC + 1);

   logic [CW-1:0] cnt;

   // This write lands in the last free slot.
   assign fill = we && !loaded && (cnt == CW'(NC - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt    <= '0;
         words  <= '0;
         loaded <= 1'b0;
      end else if (clr) begin
         // Counts restart; stored words are kept.
         cnt    <= '0;
         loaded <= 1'b0;
      end else if (we && !loaded) begin
         for (int j = 0; j < NC; j++) begin
            if (cnt == CW'(j)) begin
               words[j*N +: N] <= din;
            end
         end
         cnt <= cnt + 1'b1;
         if (fill) begin
            loaded <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/coef_bank.sv
// coef_bank: loads ND nodes of NC coefficients from a shared bus, then drains them.
// Ports: clk, rst, c_we, din, drain -> coef, loaded, dout, dout_vld, busy, err.
// Macro COEF_BANK_ERR_EN enables the sticky protocol-error flag; otherwise err is 0.
module coef_bank
   import coef_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int ND = ND_DEF,
   parameter int NC = NC_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [ND-1:0]      c_we,
   input  logic [N-1:0]       din,
   input  logic               drain,
   output logic [ND*NC*N-1:0] coef,
   output logic [ND-1:0]      loaded,
   output logic [N-1:0]       dout,
   output logic               dout_vld,
   output logic               busy,
   output logic               err
);

   localparam int TOT = ND * NC;
   localparam int IW  = $clog2(TOT + 1);
   localparam logic [IW-1:0] LAST = IW'(TOT);

   state_t        state;
   logic [IW-1:0] idx;
   logic [ND-1:0] sel;
   logic [ND-1:0] node_we;
   logic [ND-1:0] fill;
   logic          any_we;
   logic          onehot;
   logic          idle_load;
   logic          wr_ok;
   logic          all_next;
   logic          clr;
   logic [N-1:0]  drain_word;

   // c_we MSB addresses node 0.
   for (genvar k = 0; k < ND; k++) begin : g_sel
      assign sel[k] = c_we[ND-1-k];
   end

   assign any_we    = |c_we;
   assign onehot    = any_we && ((c_we & (c_we - 1'b1)) == '0);
   assign idle_load = (state == IDLE) || (state == LOAD);
   assign wr_ok     = idle_load && onehot && ((sel & loaded) == '0);
   assign node_we   = wr_ok ? sel : '0;
   assign all_next  = &(loaded | fill);
   assign clr       = (state == DRAIN) && (idx == LAST);

   for (genvar k = 0; k < ND; k++) begin : g_node
      coef_node #(
         .N  (N),
         .NC (NC)
      ) u_node (
         .clk    (clk),
         .rst    (rst),
         .we     (node_we[k]),
         .clr    (clr),
         .din    (din),
         .words  (coef[k*NC*N +: NC*N]),
         .loaded (loaded[k]),
         .fill   (fill[k])
      );
   end

   // Flattened layout already matches drain order.
   always_comb begin
      drain_word = '0;
      for (int i = 0; i < TOT; i++) begin
         if (idx == IW'(i)) begin
            drain_word = coef[i*N +: N];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         idx      <= '0;
         dout     <= '0;
         dout_vld <= 1'b0;
         busy     <= 1'b0;
      end else begin
         unique case (state)
            IDLE, LOAD: begin
               if (wr_ok) begin
                  state <= all_next ? READY : LOAD;
               end
            end
            READY: begin
               if (drain) begin
                  // Word 0 goes out the cycle after drain.
                  state    <= DRAIN;
                  dout     <= coef[0 +: N];
                  dout_vld <= 1'b1;
                  busy     <= 1'b1;
                  idx      <= IW'(1);
               end
            end
            DRAIN: begin
               if (idx == LAST) begin
                  state    <= IDLE;
                  dout_vld <= 1'b0;
                  busy     <= 1'b0;
                  idx      <= '0;
               end else begin
                  dout <= drain_word;
                  idx  <= idx + 1'b1;
               end
            end
         endcase
      end
   end

`ifdef COEF_BANK_ERR_EN
   logic illegal;

   // Any non-idle c_we that is not an accepted write.
   assign illegal = any_we && !wr_ok;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err <= 1'b0;
      end else if (illegal) begin
         err <= 1'b1;
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_coef_bank.sv
// tb_coef_bank: scoreboard bench for coef_bank (ND=4, NC=4, N=16).
// Covers reset, load, overflow, multi-hot, drain, drain+write, mid-drain reset.
module tb_coef_bank;
   import coef_pkg::*;

   localparam int N   = 16;
   localparam int ND  = 4;
   localparam int NC  = 4;
   localparam int TOT = ND * NC;

`ifdef COEF_BANK_ERR_EN
   localparam logic ERRV = 1'b1;
`else
   localparam logic ERRV = 1'b0;
`endif

   logic               clk;
   logic               rst;
   logic [ND-1:0]      c_we;
   logic [N-1:0]       din;
   logic               drain;
   logic [ND*NC*N-1:0] coef;
   logic [ND-1:0]      loaded;
   logic [N-1:0]       dout;
   logic               dout_vld;
   logic               busy;
   logic               err;

   int tests;
   int fails;

   logic [N-1:0] model [TOT];
   logic [N-1:0] sb [$];

   coef_bank #(.N(N), .ND(ND), .NC(NC)) dut (
      .clk      (clk),
      .rst      (rst),
      .c_we     (c_we),
      .din      (din),
      .drain    (drain),
      .coef     (coef),
      .loaded   (loaded),
      .dout     (dout),
      .dout_vld (dout_vld),
      .busy     (busy),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [ND*NC*N-1:0] exp_coef();
      logic [ND*NC*N-1:0] v;
      for (int i = 0; i < TOT; i++) v[i*N +: N] = model[i];
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Legal write of word w (node w/NC, slot w%NC).
   task automatic load_word(input int w, input logic [N-1:0] v);
      c_we = 4'b1000 >> (w / NC);
      din  = v;
      tick();
      c_we = '0;
      model[w] = v;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #3;
      for (int i = 0; i < TOT; i++) model[i] = '0;
      tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      c_we = '0; din = '0; drain = 1'b0;
      rst = 1'b0;
      #3;
      for (int i = 0; i < TOT; i++) model[i] = '0;
      tests++;
      if (coef !== '0) begin fails++; $display("FAIL reset_coef got %h exp 0", coef); end
      tests++;
      if (loaded !== 4'b0000) begin fails++; $display("FAIL reset_loaded got %b exp 0000", loaded); end
      tests++;
      if (dout !== '0 || dout_vld !== 1'b0 || busy !== 1'b0)
         begin fails++; $display("FAIL reset_out got dout=%h vld=%b busy=%b exp 0/0/0", dout, dout_vld, busy); end
      tests++;
      if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b exp 0", err); end
      tests++;
      if (dut.state !== IDLE) begin fails++; $display("FAIL reset_state got %0d exp IDLE", dut.state); end
      tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic test_overflow();
      // node 0 is full here
      c_we = 4'b1000; din = 16'hAAAA;
      tick();
      c_we = '0;
      tests++;
      if (coef !== exp_coef()) begin fails++; $display("FAIL overflow_coef got %h exp %h", coef, exp_coef()); end
      tests++;
      if (loaded !== 4'b0001) begin fails++; $display("FAIL overflow_loaded got %b exp 0001", loaded); end
      tests++;
      if (err !== ERRV) begin fails++; $display("FAIL overflow_err got %b exp %b", err, ERRV); end
   endtask

   task automatic test_multihot();
      c_we = 4'b1100; din = 16'h7FFF;
      tick();
      c_we = '0;
      tests++;
      if (coef !== exp_coef()) begin fails++; $display("FAIL multihot_coef got %h exp %h", coef, exp_coef()); end
      tests++;
      if (err !== ERRV) begin fails++; $display("FAIL multihot_err got %b exp %b", err, ERRV); end
   endtask

   task automatic test_drain_in_load();
      tests++;
      if (loaded !== 4'b0011) begin fails++; $display("FAIL dil_loaded got %b exp 0011", loaded); end
      drain = 1'b1;
      tick();
      drain = 1'b0;
      tests++;
      if (dout_vld !== 1'b0 || busy !== 1'b0)
         begin fails++; $display("FAIL dil_vld got vld=%b busy=%b exp 0/0", dout_vld, busy); end
      tests++;
      if (dut.state !== LOAD) begin fails++; $display("FAIL dil_state got %0d exp LOAD", dut.state); end
      tick();
      tests++;
      if (dout_vld !== 1'b0) begin fails++; $display("FAIL dil_vld2 got %b exp 0", dout_vld); end
   endtask

   task automatic test_full_load();
      for (int w = 0; w < 4; w++) load_word(w, N'(w + 1));
      test_overflow();
      test_multihot();
      for (int w = 4; w < 8; w++) load_word(w, N'(w + 1));
      test_drain_in_load();
      for (int w = 8; w < 16; w++) load_word(w, N'(w + 1));
      tests++;
      if (loaded !== 4'b1111) begin fails++; $display("FAIL load_loaded got %b exp 1111", loaded); end
      tests++;
      if (dut.state !== READY) begin fails++; $display("FAIL load_state got %0d exp READY", dut.state); end
      tests++;
      if (coef[(2*NC+1)*N +: N] !== 16'd10)
         begin fails++; $display("FAIL load_n2s1 got %0d exp 10", coef[(2*NC+1)*N +: N]); end
      tests++;
      if (coef !== exp_coef()) begin fails++; $display("FAIL load_coef got %h exp %h", coef, exp_coef()); end
   endtask

   // Drain with optional simultaneous c_we; checks the full stream.
   task automatic run_drain(input string nm, input logic [ND-1:0] cw);
      logic [N-1:0] e;
      for (int i = 0; i < TOT; i++) sb.push_back(model[i]);
      drain = 1'b1; c_we = cw; din = 16'h5A5A;
      tick();
      drain = 1'b0; c_we = '0;
      for (int i = 0; i < TOT; i++) begin
         e = sb.pop_front();
         tests++;
         if (dout_vld !== 1'b1 || busy !== 1'b1 || dout !== e)
            begin fails++; $display("FAIL %s_word%0d got dout=%h vld=%b busy=%b exp %h/1/1", nm, i, dout, dout_vld, busy, e); end
         tick();
      end
      tests++;
      if (dout_vld !== 1'b0 || busy !== 1'b0 || dout !== model[TOT-1])
         begin fails++; $display("FAIL %s_end got dout=%h vld=%b busy=%b exp %h/0/0", nm, dout, dout_vld, busy, model[TOT-1]); end
      tests++;
      if (dut.state !== IDLE || loaded !== 4'b0000)
         begin fails++; $display("FAIL %s_idle got state=%0d loaded=%b exp IDLE/0000", nm, dut.state, loaded); end
      tests++;
      if (coef !== exp_coef()) begin fails++; $display("FAIL %s_retain got %h exp %h", nm, coef, exp_coef()); end
   endtask

   task automatic test_drain();
      run_drain("drain", 4'b0000);
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int w = 0; w < TOT; w++) load_word(w, N'(16'h0100 + w * 3));
      tests++;
      if (err !== 1'b0 || dut.state !== READY)
         begin fails++; $display("FAIL b2b_pre got err=%b state=%0d exp 0/READY", err, dut.state); end
      run_drain("b2b", 4'b0010);
      tests++;
      if (err !== ERRV) begin fails++; $display("FAIL b2b_err got %b exp %b", err, ERRV); end
      // Reload over retained words once counts are clear.
      for (int w = 0; w < TOT; w++) load_word(w, N'(16'h0F00 - w));
      tests++;
      if (coef !== exp_coef() || loaded !== 4'b1111)
         begin fails++; $display("FAIL reload got %h/%b exp %h/1111", coef, loaded, exp_coef()); end
   endtask

   task automatic test_mid_drain_reset();
      drain = 1'b1;
      tick();
      drain = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tests++;
         if (dout_vld !== 1'b1 || dout !== model[i])
            begin fails++; $display("FAIL mdr_word%0d got %h vld=%b exp %h", i, dout, dout_vld, model[i]); end
         if (i < 4) tick();
      end
      rst = 1'b0;
      #1;
      tests++;
      if (dout_vld !== 1'b0 || busy !== 1'b0 || dout !== '0)
         begin fails++; $display("FAIL mdr_out got dout=%h vld=%b busy=%b exp 0/0/0", dout, dout_vld, busy); end
      tests++;
      if (coef !== '0 || loaded !== 4'b0000)
         begin fails++; $display("FAIL mdr_clear got %h/%b exp 0/0000", coef, loaded); end
      tests++;
      if (dut.state !== IDLE || err !== 1'b0)
         begin fails++; $display("FAIL mdr_state got state=%0d err=%b exp IDLE/0", dut.state, err); end
      tick();
      rst = 1'b1;
      tick();
      tick();
      tests++;
      if (dout_vld !== 1'b0 || busy !== 1'b0)
         begin fails++; $display("FAIL mdr_after got vld=%b busy=%b exp 0/0", dout_vld, busy); end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_full_load();
      test_drain();
      test_back_to_back();
      test_mid_drain_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running exp finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/coef_bank.md
COEF_BANK -- requirements
Module: coef_bank

Interface
REQ-001 SHALL have parameter N, default 16, meaning bit width of one fixed-point coefficient word.
REQ-002 SHALL have parameter ND, default 4, meaning total nodes served, one per bit of c_we.
REQ-003 SHALL have parameter NC, default 4, meaning coefficients per node (fan-in plus bias).
REQ-004 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port c_we  input  ND  one-hot node write enable from control unit; MSB = node 0.
REQ-007 SHALL have port din  input  N  coefficient word from the shared bus.
REQ-008 SHALL have port drain  input  1  single-cycle request to read all coefficients back out.
REQ-009 SHALL have port coef  output  ND*NC*N  flattened storage; node k slot j at bits [(k*NC+j)*N +: N].
REQ-010 SHALL have port loaded  output  ND  bit k high once node k holds NC words.
REQ-011 SHALL have port dout  output  N  drained word.
REQ-012 SHALL have port dout_vld  output  1  dout qualifier.
REQ-013 SHALL have port busy  output  1  high in DRAIN.
REQ-014 SHALL have port err  output  1  sticky protocol-error flag.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, READY, DRAIN.
REQ-016 SHALL, in IDLE or LOAD with exactly one c_we bit k set and node k count < NC, write din into node k slot count and increment count; next coef visible one cycle later.
REQ-017 SHALL move IDLE->LOAD on the first accepted write.
REQ-018 SHALL set loaded[k] on the edge that makes node k count equal NC; counts saturate at NC.
REQ-019 SHALL move LOAD->READY on the edge where all loaded bits become 1.
REQ-020 SHALL ignore a write to a full node, a multi-hot c_we, or any c_we in READY/DRAIN, and set err.
REQ-021 SHALL, on drain in READY, enter DRAIN and emit ND*NC words on consecutive cycles starting next cycle, order node 0..ND-1, slot 0..NC-1, dout_vld high each cycle.
REQ-022 SHALL, after the last word, return to IDLE, clear all counts and loaded bits, and retain coef values.
REQ-023 SHALL ignore drain outside READY; drain and c_we together in READY: drain taken, write dropped, err set.
REQ-024 SHALL hold dout at last value and dout_vld low when not draining.

Reset
REQ-025 SHALL, on rst low, asynchronously force state IDLE, coef all zero, counts zero, loaded zero, dout zero, dout_vld 0, busy 0, err 0.
REQ-026 SHALL abort any LOAD or DRAIN in progress on reset without emitting further words.

Configuration
REQ-027 SHALL use macro COEF_BANK_ERR_EN: defined -> err logic per REQ-020/023; undefined -> err tied 0, illegal writes still dropped silently.

Structure
REQ-028 SHALL place the state enumeration and default N/ND/NC constants in shared package coef_pkg; N default sourced from the fixed-point header width.
REQ-029 SHALL instantiate ND copies of sub-module coef_node (one node's NC-word store plus saturating counter and loaded flag).

Verification
REQ-030 SHALL cover full load: ND=4,NC=4, 16 writes din=1..16 with c_we 1000,0100,0010,0001 four cycles each -> loaded=1111, state READY, node 2 slot 1 = 10.
REQ-031 SHALL cover drain: drain pulse in READY -> dout 1..16 on 16 consecutive cycles, busy high 16 cycles, then IDLE, loaded=0000.
REQ-032 SHALL cover overflow: fifth write to node 0 -> coef unchanged, err=1 (ERR_EN defined), err=0 (undefined).
REQ-033 SHALL cover multi-hot: c_we=1100, din=0x7FFF -> no coef change, err=1.
REQ-034 SHALL cover mid-drain reset: rst low at word 5 -> dout_vld 0 same cycle, coef zero, state IDLE.
REQ-035 SHALL cover drain in LOAD with loaded=0011 -> ignored, no dout_vld, load continues normally.
